cla_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first. The inter-slice carry is held in a register. Valid/ready handshakes sit on both the operand side and the result side. It is used where area matters more than throughput, ahead of wider arithmetic built from the 4-bit CLA.

---
 rtl/cla_serial_add_ctrl_pkg.sv | 15 +
 rtl/cla_serial_add_ctrl_cla.sv | 27 ++
 rtl/cla_serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial CLA adder sequencer.
package cla_serial_add_ctrl_pkg;
  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width must be a whole number of nibbles, at least one.
  function automatic bit width_ok(input int w);
    return (w >= NIB) && ((w % NIB) == 0);
  endfunction
endpackage

// File: rtl/cla_serial_add_ctrl_cla.sv
// 4-bit carry-lookahead slice: flat generate/propagate equations, no ripple.
module carry_lookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a two-level function of g/p and cin.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit add/subtract built by running one 4-bit CLA slice once per nibble,
// LSB first, with the inter-nibble carry held in a register.
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NSLICE = WIDTH / NIB;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt, sum_q;
  logic            cout_q, ovf_q;
  logic [NIB-1:0]  sa, sb, ss;
  logic            sc;
  logic            last;

  // Select the operand nibbles for the current pass.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        sa = a_q[k*NIB +: NIB];
        sb = b_q[k*NIB +: NIB];
      end
    end
  end

  carry_lookahead_adder u_slice (
    .a   (sa),
    .b   (sb),
    .cin (carry),
    .sum (ss),
    .cout(sc)
  );

  // Working sum with the current pass's nibble merged in.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) acc_nxt[k*NIB +: NIB] = ss;
    end
  end

  assign last = (cnt == CW'(NSLICE - 1));

  // Sequencer: accept operands, step the slice across nibbles, hold the result.
  // The working sum (acc) is separate from the presented result (sum_q), so a
  // partially built sum never appears on out_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_sub ? ~in_b : in_b;
            carry <= in_sub ? 1'b1 : in_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= sc;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= acc_nxt;
            cout_q <= sc;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ss[NIB-1] != a_q[WIDTH-1]);
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl at WIDTH=16, plus WIDTH=4/32 sweeps.
module tb_cla_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  // WIDTH=16
  logic        iv = 0, ir, ic = 0, isb = 0, ov, ordy = 0, oc, oo;
  logic [15:0] ia = 0, ib = 0, os;
  // WIDTH=4
  logic        iv4 = 0, ir4, ic4 = 0, isb4 = 0, ov4, ordy4 = 0, oc4, oo4;
  logic [3:0]  ia4 = 0, ib4 = 0, os4;
  // WIDTH=32
  logic        iv32 = 0, ir32, ic32 = 0, isb32 = 0, ov32, ordy32 = 0, oc32, oo32;
  logic [31:0] ia32 = 0, ib32 = 0, os32;

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib),
    .in_cin(ic), .in_sub(isb), .out_valid(ov), .out_ready(ordy), .out_sum(os),
    .out_cout(oc), .out_ovf(oo));

  cla_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(ia4), .in_b(ib4),
    .in_cin(ic4), .in_sub(isb4), .out_valid(ov4), .out_ready(ordy4), .out_sum(os4),
    .out_cout(oc4), .out_ovf(oo4));

  cla_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(ia32), .in_b(ib32),
    .in_cin(ic32), .in_sub(isb32), .out_valid(ov32), .out_ready(ordy32), .out_sum(os32),
    .out_cout(oc32), .out_ovf(oo32));

  // Offer one operand set (DUT assumed idle), then wait boundedly for out_valid.
  // lat is the cycle index of first out_valid, counting the accept cycle as 0.
  task automatic op16(input logic [15:0] a, b, input logic cin, sub,
                      output logic [15:0] s, output logic c, o, output int lat, output bit irbad);
    @(negedge clk); ia = a; ib = b; ic = cin; isb = sub; iv = 1;
    @(posedge clk); #1 iv = 0; ia = 16'hDEAD; ib = 16'hBEEF; ic = ~cin; isb = ~sub;
    lat = 1; irbad = 0;
    while (1) begin
      @(negedge clk);
      if (ir) irbad = 1;
      if (ov || lat > 40) break;
      lat++;
    end
    s = os; c = oc; o = oo;
  endtask

  task automatic take16();
    @(negedge clk); ordy = 1;
    @(posedge clk); #1 ordy = 0;
  endtask

  task automatic test_reset();
    #2;
    ntot++; if (ov !== 0)        $display("FAIL rst_valid got %b want 0", ov); else npass++;
    ntot++; if (os !== 16'h0)    $display("FAIL rst_sum got %h want 0000", os); else npass++;
    ntot++; if ({oc, oo} !== 2'b00) $display("FAIL rst_cout_ovf got %b want 00", {oc, oo}); else npass++;
    ntot++; if (ir !== 1)        $display("FAIL rst_in_ready got %b want 1", ir); else npass++;
    iv = 1; ia = 16'h1111; ib = 16'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; iv = 0;
    @(negedge clk);
    ntot++; if ({ir, ov} !== 2'b10) $display("FAIL rst_no_transfer got %b want 10", {ir, ov}); else npass++;
  endtask

  task automatic test_add();
    logic [15:0] s; logic c, o; int lat; bit irbad;
    op16(16'h1234, 16'h0FFF, 0, 0, s, c, o, lat, irbad);
    ntot++; if (lat !== 5) $display("FAIL add_latency got %0d want 5", lat); else npass++;
    ntot++; if (irbad)     $display("FAIL add_in_ready_busy got 1 want 0"); else npass++;
    ntot++; if ({s, c, o} !== {16'h2233, 2'b00}) $display("FAIL add_1234_0fff got %h/%b%b want 2233/00", s, c, o); else npass++;
    take16();
    @(negedge clk);
    ntot++; if ({ir, ov} !== 2'b10) $display("FAIL add_idle_after_take got %b want 10", {ir, ov}); else npass++;
    op16(16'h0001, 16'h0001, 1, 0, s, c, o, lat, irbad);
    ntot++; if ({s, c, o} !== {16'h0003, 2'b00}) $display("FAIL add_cin got %h/%b%b want 0003/00", s, c, o); else npass++;
    take16();
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, o; int lat; bit irbad;
    op16(16'hFFFF, 16'h0001, 0, 0, s, c, o, lat, irbad);
    ntot++; if ({s, c, o} !== {16'h0000, 2'b10}) $display("FAIL carry_ripple got %h/%b%b want 0000/10", s, c, o); else npass++;
    take16();
    op16(16'h7FFF, 16'h0001, 0, 0, s, c, o, lat, irbad);
    ntot++; if ({s, c, o} !== {16'h8000, 2'b01}) $display("FAIL add_ovf got %h/%b%b want 8000/01", s, c, o); else npass++;
    take16();
  endtask

  task automatic test_sub();
    logic [15:0] s; logic c, o; int lat; bit irbad;
    op16(16'h0005, 16'h0007, 1, 1, s, c, o, lat, irbad);
    ntot++; if ({s, c, o} !== {16'hFFFE, 2'b00}) $display("FAIL sub_borrow got %h/%b%b want fffe/00", s, c, o); else npass++;
    take16();
    op16(16'h8000, 16'h0001, 1, 1, s, c, o, lat, irbad);
    ntot++; if ({s, c, o} !== {16'h7FFF, 2'b11}) $display("FAIL sub_ovf got %h/%b%b want 7fff/11", s, c, o); else npass++;
    take16();
  endtask

  task automatic test_backpressure();
    logic [15:0] s; logic c, o; int lat; bit irbad;
    op16(16'h8000, 16'h0001, 0, 1, s, c, o, lat, irbad);
    ntot++; if ({s, c, o} !== {16'h7FFF, 2'b11}) $display("FAIL bp_result got %h/%b%b want 7fff/11", s, c, o); else npass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); iv = 1; ia = 16'(i * 16'h1357); ib = 16'(16'h0F0F + i); isb = i[0];
      #1;
      ntot++;
      if ({ov, ir, os, oc, oo} !== {2'b10, 16'h7FFF, 2'b11})
        $display("FAIL bp_hold%0d got v%b r%b %h/%b%b want v1 r0 7fff/11", i, ov, ir, os, oc, oo);
      else npass++;
    end
    @(negedge clk); ordy = 1;
    @(posedge clk); #1 ordy = 0; iv = 0;
    @(negedge clk);
    ntot++; if ({ir, ov} !== 2'b10) $display("FAIL bp_idle_after_take got %b want 10", {ir, ov}); else npass++;
    @(negedge clk);
    ntot++; if (ir !== 1) $display("FAIL bp_no_accept_on_take got in_ready %b want 1", ir); else npass++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s; logic c, o; int lat; bit irbad;
    @(negedge clk); ia = 16'h1234; ib = 16'h1111; ic = 0; isb = 0; iv = 1;
    @(posedge clk); #1 iv = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    ntot++;
    if ({ov, os, oc, oo, ir} !== {1'b0, 16'h0, 3'b001})
      $display("FAIL rst_mid_run got v%b %h/%b%b r%b want v0 0000/00 r1", ov, os, oc, oo, ir);
    else npass++;
    @(negedge clk); rst = 0;
    op16(16'h0001, 16'h0001, 0, 0, s, c, o, lat, irbad);
    ntot++; if (lat !== 5) $display("FAIL post_rst_latency got %0d want 5", lat); else npass++;
    ntot++; if ({s, c, o} !== {16'h0002, 2'b00}) $display("FAIL post_rst_sum got %h/%b%b want 0002/00", s, c, o); else npass++;
    take16();
  endtask

  task automatic test_sweep4();
    logic [3:0] a, b, be; logic cin, sub, ci; logic [4:0] r; logic eo; int lat;
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom); b = 4'($urandom); sub = i[0]; cin = 1'($urandom);
      if (i == 0) begin a = 4'hF; b = 4'h1; sub = 0; cin = 0; end
      be = sub ? ~b : b; ci = sub ? 1'b1 : cin;
      r  = 5'({1'b0, a}) + 5'({1'b0, be}) + 5'(ci);
      eo = (a[3] == be[3]) && (r[3] != a[3]);
      @(negedge clk); ia4 = a; ib4 = b; ic4 = cin; isb4 = sub; iv4 = 1;
      @(posedge clk); #1 iv4 = 0;
      lat = 1;
      while (1) begin @(negedge clk); if (ov4 || lat > 40) break; lat++; end
      if (i == 0) begin
        ntot++; if (lat !== 2) $display("FAIL w4_latency got %0d want 2", lat); else npass++;
      end
      ntot++;
      if ({os4, oc4, oo4} !== {r[3:0], r[4], eo})
        $display("FAIL w4_op%0d %h%s%h got %h/%b%b want %h/%b%b", i, a, sub ? "-" : "+", b, os4, oc4, oo4, r[3:0], r[4], eo);
      else npass++;
      @(negedge clk); ordy4 = 1;
      @(posedge clk); #1 ordy4 = 0;
    end
  endtask

  task automatic test_sweep32();
    logic [31:0] a, b, be; logic cin, sub, ci; logic [32:0] r; logic eo; int lat;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; sub = i[0]; cin = 1'($urandom);
      if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'h1; sub = 0; cin = 0; end
      be = sub ? ~b : b; ci = sub ? 1'b1 : cin;
      r  = 33'({1'b0, a}) + 33'({1'b0, be}) + 33'(ci);
      eo = (a[31] == be[31]) && (r[31] != a[31]);
      @(negedge clk); ia32 = a; ib32 = b; ic32 = cin; isb32 = sub; iv32 = 1;
      @(posedge clk); #1 iv32 = 0;
      lat = 1;
      while (1) begin @(negedge clk); if (ov32 || lat > 40) break; lat++; end
      if (i == 0) begin
        ntot++; if (lat !== 9) $display("FAIL w32_latency got %0d want 9", lat); else npass++;
      end
      ntot++;
      if ({os32, oc32, oo32} !== {r[31:0], r[32], eo})
        $display("FAIL w32_op%0d %h%s%h got %h/%b%b want %h/%b%b", i, a, sub ? "-" : "+", b, os32, oc32, oo32, r[31:0], r[32], eo);
      else npass++;
      @(negedge clk); ordy32 = 1;
      @(posedge clk); #1 ordy32 = 0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_sweep4();
    test_sweep32();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
